// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module   : ps2_pkg
// Purpose  : Shared PS/2 transmit constants, FSM state encoding and the
//            odd-parity helper used by the key transmitter and its serializer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  // Prefix byte sent ahead of the scan code on a key release
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Transmitter sequencing states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PREFIX = 3'd1;
  localparam logic [2:0] ST_GAP1   = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_GAP2   = 3'd4;

  // PS/2 parity bit: makes the count of ones over data+parity odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_ser.sv
//------------------------------------------------------------------------------
// Module   : ps2_frame_ser
// Purpose  : Serializes one byte as an 11-bit PS/2 device frame. Each bit is
//            2*CLK_DIV cycles: data changes with ps2_clk high, ps2_clk falls
//            halfway through. byte_done marks the edge ending the stop bit.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       byte_done
);

  localparam int           DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]   LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic          r_active;
  logic          r_low;      // 0: high half of the bit, 1: low half
  logic [DW-1:0] r_div;
  logic [3:0]    r_bit;
  logic [10:0]   r_frame;    // r_frame[0] is the bit currently on ps2_data

  logic w_half_end;

  assign w_half_end = (r_div == DIV_LAST);
  // Combinational so the sequencer can react on the very edge the frame ends
  assign byte_done  = r_active && r_low && w_half_end && (r_bit == LAST_BIT);

  // Bit/half-period sequencing and registered line drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_low    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_frame  <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (start) begin
      r_active <= 1'b1;
      r_low    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_frame  <= {1'b1, odd_parity(din), din, 1'b0};
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b0;
    end else if (r_active) begin
      if (!w_half_end) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div <= '0;
        if (!r_low) begin
          r_low   <= 1'b1;
          ps2_clk <= 1'b0;
        end else begin
          r_low   <= 1'b0;
          ps2_clk <= 1'b1;
          if (r_bit == LAST_BIT) begin
            r_active <= 1'b0;
            ps2_data <= 1'b1;
          end else begin
            r_bit    <= r_bit + 1'b1;
            r_frame  <= {1'b1, r_frame[10:1]};
            ps2_data <= r_frame[1];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_tx.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_tx
// Purpose  : Device-side PS/2 keyboard emulator. Accepts code/brk over a
//            valid/ready handshake and sends either the code alone (make) or
//            F0 followed by the code (break), each byte followed by an idle gap.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_key_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int GAP_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] code,
  input  logic       brk,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  logic [2:0]    r_state;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_code;

  logic       w_accept;
  logic       w_gap_end;
  logic       w_ser_start;
  logic [7:0] w_ser_byte;
  logic       w_byte_done;

  assign w_accept    = valid && ready && (r_state == ST_IDLE);
  assign w_gap_end   = (r_gap == GAP_LAST);
  // The serializer starts on the accept edge so the start bit appears in the
  // very next cycle; the second byte of a break starts as GAP1 expires.
  assign w_ser_start = w_accept || ((r_state == ST_GAP1) && w_gap_end);
  assign w_ser_byte  = (r_state == ST_IDLE) ? (brk ? PS2_BREAK_PREFIX : code) : r_code;

  ps2_frame_ser #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (w_ser_start),
    .din       (w_ser_byte),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_done (w_byte_done)
  );

  // Handshake, prefix/gap sequencing and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_code  <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code  <= code;
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_state <= brk ? ST_PREFIX : ST_SEND;
          end
        end
        ST_PREFIX: begin
          if (w_byte_done) begin
            r_gap   <= '0;
            r_state <= ST_GAP1;
          end
        end
        ST_GAP1: begin
          if (w_gap_end) begin
            r_gap   <= '0;
            r_state <= ST_SEND;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_SEND: begin
          if (w_byte_done) begin
            r_gap   <= '0;
            r_state <= ST_GAP2;
          end
        end
        ST_GAP2: begin
          if (w_gap_end) begin
            r_gap   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_gap   <= '0;
          ready   <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_key_tx
// Purpose  : Scoreboard bench for ps2_key_tx. Requests push expected bytes,
//            fall times and done times; host-side monitors pop and compare.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_key_tx;

  localparam int CD    = 4;
  localparam int GC    = 8;
  localparam int FRAME = 22 * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] code;
  logic       brk;
  logic       ready, busy, done, ps2_clk, ps2_data;

  ps2_key_tx #(.CLK_DIV(CD), .GAP_CYC(GC)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .code     (code),
    .brk      (brk),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         base;   // cycle of the edge that starts this byte
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_total = 0;
  int   exp_done_total = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: a request becomes one or two bytes, each a full frame
  // plus an idle gap, with done at the end of the last gap.
  task automatic push_expect(input logic [7:0] c, input logic b, input int acc);
    if (b) begin
      exp_q.push_back('{b: 8'hF0, base: acc});
      exp_q.push_back('{b: c, base: acc + FRAME + GC});
      done_q.push_back(acc + 2 * (FRAME + GC));
    end else begin
      exp_q.push_back('{b: c, base: acc});
      done_q.push_back(acc + FRAME + GC);
    end
    exp_done_total++;
  endtask

  task automatic send(input logic [7:0] c, input logic b, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_wait_timeout", 1, 0);
    valid = 1'b1;
    code  = c;
    brk   = b;
    @(posedge clk);
    #1;
    last_acc = cyc;
    push_expect(c, b, cyc);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || !ready) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("quiet_timeout", (n < 6000), 1);
    repeat (30) @(negedge clk);
  endtask

  // Host-side receiver: samples ps2_data on every ps2_clk fall
  logic [10:0] rx_bits;
  int          nb = 0;
  always @(negedge ps2_clk or posedge rst) begin
    if (rst) begin
      nb = 0;
    end else begin
      chk("ready_in_frame", ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_fall", 1, 0);
      end else begin
        chk("fall_cycle", cyc, exp_q[0].base + CD + 2 * CD * nb);
        rx_bits[nb] = ps2_data;
        nb++;
        if (nb == 11) begin
          exp_t       e;
          logic       par;
          logic [10:0] want;
          e    = exp_q.pop_front();
          par  = ($countones(e.b) % 2 == 0);
          want = {1'b1, par, e.b, 1'b0};
          chk("frame_bits", rx_bits, want);
          nb = 0;
        end
      end
    end
  end

  // done monitor
  always @(negedge clk) begin
    if (rst !== 1'b1 && done === 1'b1) begin
      done_total++;
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
      chk("ready_at_done", ready, 1);
      chk("busy_at_done", busy, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst   = 1'b1;
    valid = 1'b0;
    code  = 8'h00;
    brk   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Make and break of 0x1C, then parity corner bytes
    send(8'h1C, 1'b0, 1'b0);
    wait_quiet();
    send(8'h1C, 1'b1, 1'b0);
    wait_quiet();
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    wait_quiet();

    // Request while busy must be dropped
    send(8'h1C, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    valid = 1'b1; code = 8'h45; brk = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_quiet();

    // Reset in the middle of bit 5
    send(8'h5A, 1'b0, 1'b0);
    a = last_acc;
    while (cyc < a + CD + 2 * CD * 5 + 1) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ps2_clk", ps2_clk, 1);
    chk("midrst_ps2_data", ps2_data, 1);
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    exp_done_total -= done_q.size();
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h29, 1'b0, 1'b0);
    wait_quiet();

    // valid held high: re-accept on the edge after done
    send(8'h16, 1'b0, 1'b1);
    a = last_acc;
    while (cyc < a + FRAME + GC + 1) @(posedge clk);
    #1;
    push_expect(8'h16, 1'b0, a + FRAME + GC + 1);
    valid = 1'b0;
    wait_quiet();

    // Randomized requests
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
    wait_quiet();

    chk("leftover_bytes", exp_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    chk("done_total", done_total, exp_done_total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
